// File: rtl/fetch_inst_queue.sv
// Instruction queue between IF and the IF/ID boundary; buffers {pc, inst} pairs and
// shows NOP when empty. Optional zero-latency bypass when FETCHQ_BYPASS_EN is defined.
module fetch_inst_queue #(
  parameter int                DEPTH    = 4,
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0340_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [PC_W-1:0]            out_pcadd4,
  output logic [INST_W-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic              not_empty;
  logic              push;
  logic              pop;

  assign not_empty = (count != '0);
  assign in_ready  = (count != CW'(DEPTH));
  assign pop       = not_empty & out_ready & ~flush;

`ifdef FETCHQ_BYPASS_EN
  logic bypass;

  // An arrival into an empty queue is forwarded straight to ID; it only needs
  // storing if ID does not take it this cycle.
  assign bypass    = ~not_empty & in_valid & ~flush;
  assign push      = in_valid & in_ready & ~flush & ~(bypass & out_ready);
  assign out_valid = not_empty | bypass;

  always_comb begin
    out_pc   = '0;
    out_inst = NOP_INST;
    if (not_empty) begin
      out_pc   = mem_pc[head];
      out_inst = mem_inst[head];
    end else if (bypass) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end
  end
`else
  assign push      = in_valid & in_ready & ~flush;
  assign out_valid = not_empty;

  always_comb begin
    out_pc   = '0;
    out_inst = NOP_INST;
    if (not_empty) begin
      out_pc   = mem_pc[head];
      out_inst = mem_inst[head];
    end
  end
`endif

  assign out_pcadd4 = out_pc + PC_W'(4);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]   <= in_pc;
      mem_inst[tail] <= in_inst;
    end
  end

  // Flush only rewinds the pointers; stale storage is unreachable afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule
